// File: rtl/cordiccart2pol_mul_arbiter.sv
// Round-robin share of one external pipelined 32s x 30u multiplier; one issue per cycle, tag tracked through MUL_LAT.
// Product returns MUL_LAT+1 cycles after issue; a requester is not granted while its op is in flight or its 1-deep response is still held.
module cordiccart2pol_mul_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int MUL_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [32*NUM_REQ-1:0]   req_a,
   input  logic [30*NUM_REQ-1:0]   req_b,
   output logic [NUM_REQ-1:0]      rsp_valid,
   input  logic [NUM_REQ-1:0]      rsp_ready,
   output logic [61*NUM_REQ-1:0]   rsp_data,
   output logic                    mul_ce,
   output logic [31:0]             mul_din0,
   output logic [29:0]             mul_din1,
   input  logic [60:0]             mul_dout,
   output logic                    busy
);

   localparam int IW = (NUM_REQ > 2) ? 2 : 1;

   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      winner;
   logic               issue;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] inflight;
   logic [IW:0]        scan_sum;
   logic [IW-1:0]      scan_idx;
   logic [MUL_LAT-1:0] stg_vld;
   logic [IW-1:0]      stg_idx [MUL_LAT];
   logic [60:0]        rsp_buf [NUM_REQ];

   always_comb begin
      inflight = '0;
      for (int s = 0; s < MUL_LAT; s++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (stg_vld[s] && (stg_idx[s] == IW'(i))) begin
               inflight[i] = 1'b1;
            end
         end
      end
   end

   // A slot draining this cycle is still occupied, so no same-cycle reuse.
   assign elig = req_valid & ~rsp_valid & ~inflight;

   always_comb begin
      issue    = 1'b0;
      winner   = '0;
      scan_sum = '0;
      scan_idx = '0;
      if (!reset) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(NUM_REQ)) begin
               scan_sum = scan_sum - (IW+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!issue && elig[scan_idx]) begin
               issue  = 1'b1;
               winner = scan_idx;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      mul_din0  = '0;
      mul_din1  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (issue && (winner == IW'(i))) begin
            req_ready[i] = 1'b1;
            mul_din0     = req_a[32*i +: 32];
            mul_din1     = req_b[30*i +: 30];
         end
      end
   end

   assign mul_ce = !reset && (issue || (|stg_vld));
   assign busy   = (|inflight) || (|rsp_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr    <= '0;
         stg_vld   <= '0;
         rsp_valid <= '0;
         for (int s = 0; s < MUL_LAT; s++) begin
            stg_idx[s] <= '0;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            rsp_buf[i] <= '0;
         end
      end else begin
         if (issue) begin
            rr_ptr <= (winner == IW'(NUM_REQ-1)) ? '0 : winner + IW'(1);
         end
         if (mul_ce) begin
            stg_vld[0] <= issue;
            stg_idx[0] <= winner;
            for (int s = 1; s < MUL_LAT; s++) begin
               stg_vld[s] <= stg_vld[s-1];
               stg_idx[s] <= stg_idx[s-1];
            end
         end
         // Capture and drain cannot hit the same index: a held response blocks new issues to it.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
            if (stg_vld[MUL_LAT-1] && (stg_idx[MUL_LAT-1] == IW'(i))) begin
               rsp_valid[i] <= 1'b1;
               rsp_buf[i]   <= mul_dout;
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
         assign rsp_data[61*g +: 61] = rsp_buf[g];
      end
   endgenerate

endmodule

// File: tb/tb_cordiccart2pol_mul_arbiter.sv
// Directed bench for the multiplier arbiter with an external 1-cycle multiplier model.
// Products are predicted at grant time and compared when the owner drains its response.
module tb_cordiccart2pol_mul_arbiter;

   localparam int NR = 2;

   logic            clk;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [63:0]     req_a;
   logic [59:0]     req_b;
   logic [NR-1:0]   rsp_valid;
   logic [NR-1:0]   rsp_ready;
   logic [121:0]    rsp_data;
   logic            mul_ce;
   logic [31:0]     mul_din0;
   logic [29:0]     mul_din1;
   logic [60:0]     mul_dout;
   logic            busy;

   int checks = 0;
   int errors = 0;
   int gcnt0, gcnt1, rcnt0, rcnt1;
   int glog[$];
   logic [60:0] q0[$];
   logic [60:0] q1[$];

   cordiccart2pol_mul_arbiter #(.NUM_REQ(NR), .MUL_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
      .mul_dout(mul_dout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External multiplier, one ce-qualified register stage.
   logic signed [60:0] ext_a, ext_b;
   assign ext_a = {{29{mul_din0[31]}}, mul_din0};
   assign ext_b = {31'b0, mul_din1};
   always_ff @(posedge clk) begin
      if (mul_ce) mul_dout <= ext_a * ext_b;
   end

   function automatic logic [60:0] model(input logic [31:0] a, input logic [29:0] b);
      longint pa, pb, pr;
      pa = {{32{a[31]}}, a};
      pb = {34'b0, b};
      pr = pa * pb;
      return pr[60:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check("grant_onehot", 64'($countones(req_ready) <= 1), 1);
      if (req_valid[0] && req_ready[0]) begin
         q0.push_back(model(req_a[31:0], req_b[29:0]));
         gcnt0++;
         glog.push_back(0);
      end
      if (req_valid[1] && req_ready[1]) begin
         q1.push_back(model(req_a[63:32], req_b[59:30]));
         gcnt1++;
         glog.push_back(1);
      end
      if (rsp_valid[0] && rsp_ready[0]) begin
         rcnt0++;
         if (q0.size() == 0) check("rsp0_unexpected", rsp_valid[0], 0);
         else check("rsp0_data", rsp_data[60:0], q0.pop_front());
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
         rcnt1++;
         if (q1.size() == 0) check("rsp1_unexpected", rsp_valid[1], 0);
         else check("rsp1_data", rsp_data[121:61], q1.pop_front());
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample();
      adv();
   endtask

   task automatic clear_counts();
      gcnt0 = 0; gcnt1 = 0; rcnt0 = 0; rcnt1 = 0;
      glog.delete();
   endtask

   initial begin
      clear_counts();
      reset     = 1'b1;
      req_valid = 2'b11;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 2'b00;
      adv();

      // Reset held with all requests asserted
      repeat (3) begin
         sample();
         check("rst_req_ready", req_ready, 0);
         check("rst_mul_ce", mul_ce, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_din0", mul_din0, 0);
         adv();
      end
      reset     = 1'b0;
      req_valid = 2'b00;
      repeat (2) tick();

      // Single op, negative operand, result two cycles after issue
      req_valid   = 2'b01;
      req_a[31:0] = 32'hFFFF_FFFD;
      req_b[29:0] = 30'd5;
      rsp_ready   = 2'b01;
      sample();
      check("t2_ready", req_ready, 2'b01);
      check("t2_din0", mul_din0, 32'hFFFF_FFFD);
      check("t2_din1", mul_din1, 30'd5);
      check("t2_ce", mul_ce, 1);
      adv();
      req_valid = 2'b00;
      sample();
      check("t2_rsp_early", rsp_valid, 0);
      check("t2_busy", busy, 1);
      adv();
      sample();
      check("t2_rsp_valid", rsp_valid, 2'b01);
      check("t2_rsp_data", rsp_data[60:0], 61'h1FFF_FFFF_FFFF_FFF1);
      adv();
      sample();
      check("t2_drained", rsp_valid, 0);
      check("t2_data_held", rsp_data[60:0], 61'h1FFF_FFFF_FFFF_FFF1);
      check("t2_idle_busy", busy, 0);
      adv();

      // Both ports continuously valid, both draining
      clear_counts();
      req_a     = {32'd2, 32'd1};
      req_b     = {30'd7, 30'd7};
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      repeat (20) tick();
      req_valid = 2'b00;
      repeat (6) tick();
      check("t3_ngrants", 64'(glog.size() >= 8), 1);
      for (int k = 1; k < glog.size(); k++) begin
         check("t3_alternate", 64'(glog[k] != glog[k-1]), 1);
      end
      check("t3_rsp0_count", rcnt0, gcnt0);
      check("t3_rsp1_count", rcnt1, gcnt1);
      check("t3_q0_empty", q0.size(), 0);
      check("t3_q1_empty", q1.size(), 0);

      // Port 1 stalled on its response
      clear_counts();
      rsp_ready = 2'b01;
      req_valid = 2'b11;
      repeat (16) tick();
      check("t4_p1_once", gcnt1, 1);
      check("t4_p0_served", 64'(gcnt0 >= 4), 1);
      check("t4_p1_held", rsp_valid[1], 1);
      clear_counts();
      rsp_ready = 2'b11;
      repeat (12) tick();
      check("t4_p1_resumed", 64'(gcnt1 >= 2), 1);
      check("t4_p0_still", 64'(gcnt0 >= 2), 1);
      req_valid = 2'b00;
      repeat (6) tick();
      check("t4_q0_empty", q0.size(), 0);
      check("t4_q1_empty", q1.size(), 0);

      // Operand extremes
      clear_counts();
      rsp_ready   = 2'b01;
      req_valid   = 2'b01;
      req_a[31:0] = 32'h8000_0000;
      req_b[29:0] = 30'h3FFF_FFFF;
      tick();
      req_valid = 2'b00;
      repeat (3) tick();
      check("t5_min_count", rcnt0, 1);
      req_valid   = 2'b01;
      req_a[31:0] = 32'h7FFF_FFFF;
      req_b[29:0] = 30'd0;
      tick();
      req_valid = 2'b00;
      tick();
      sample();
      check("t5_zero_valid", rsp_valid[0], 1);
      check("t5_zero_data", rsp_data[60:0], 0);
      adv();
      tick();
      check("t5_q0_empty", q0.size(), 0);

      // Reset right after an issue discards the op
      req_valid   = 2'b01;
      req_a[31:0] = 32'd9;
      req_b[29:0] = 30'd9;
      sample();
      check("t6_issue", req_ready, 2'b01);
      adv();
      q0.delete();
      reset     = 1'b1;
      req_valid = 2'b00;
      tick();
      reset = 1'b0;
      repeat (5) begin
         sample();
         check("t6_no_rsp", rsp_valid, 0);
         check("t6_busy", busy, 0);
         adv();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
